branch_target_buffer: RTL and testbench
=======================================

// Module: branch_target_buffer
// PURPOSE
//  Direct-mapped branch target buffer with 2-bit saturating predictors; upstream of NPC_Generator.
//  Looks up the current IF-stage PC combinationally and supplies a predicted-taken flag plus a target.
//  The IF-side mux uses these to choose between the predicted target and PC+4.
//  EX stage trains the table with resolved branch outcomes; block also keeps branch/mispredict perf counters.
// PARAMETERS
//  IDX_W     6   index width; ENTRIES = 2**IDX_W (64 entries)
//  CNT_INIT  2   counter value on allocation (2'b10 = weakly taken)
// PORTS
//  clk            in   1   core clock; all state updates on rising edge
//  rst            in   1   synchronous, active-high reset
//  PC_IF          in   32  PC of instruction in IF (lookup address)
//  pred_taken     out  1   1 = hit and counter[1]==1
//  pred_target    out  32  stored target on hit; PC_IF+4 otherwise
//  upd_valid      in   1   EX reports a resolved conditional branch this cycle
//  upd_pc         in   32  PC of the resolved branch
//  upd_target     in   32  computed branch target (br_target)
//  upd_taken      in   1   actual outcome
//  upd_mispred    in   1   EX detected wrong prediction (flush issued)
//  br_count       out  32  resolved branches since reset
//  mispred_count  out  32  mispredictions since reset
// BEHAVIOUR
//  Address split: index = pc[IDX_W+1:2], tag = pc[31:IDX_W+2]; pc[1:0] ignored.
//  Entry = {valid, tag, target[31:0], cnt[1:0]}.
//  Lookup (combinational, 0 latency): hit = valid[idx] && tag[idx]==PC_IF tag.
//   pred_taken = hit & cnt[1]; pred_target = pred_taken ? target : PC_IF+4 (32-bit wrap).
//  Update (registered, visible to lookups the cycle after upd_valid):
//   hit & taken     : cnt = sat_inc(cnt); target <= upd_target.
//   hit & !taken    : cnt = sat_dec(cnt); target unchanged; entry stays valid.
//   miss & taken    : allocate/replace: valid=1, new tag, target=upd_target, cnt=CNT_INIT.
//   miss & !taken   : no write.
//   Counter saturates at 2'b11 and 2'b00; never wraps.
//  Same-cycle lookup and update to the same index: lookup returns pre-update contents (no bypass).
//  Perf counters: br_count += upd_valid; mispred_count += upd_valid & upd_mispred.
//   Both wrap modulo 2**32. upd_mispred without upd_valid is ignored.
//  Reset (rst=1 at edge): all valid bits cleared, both perf counters = 0.
//   Target/tag/cnt arrays need no reset. Outputs after reset: pred_taken=0, pred_target=PC_IF+4.
//   rst has priority over a concurrent upd_valid; that update is dropped.
//  No stall input; lookups are pure functions of PC_IF and table state. EX must present each branch once.
// STRUCTURE
//  Shared package: CNT_SNT=2'b00, CNT_WNT=2'b01, CNT_WT=2'b10, CNT_ST=2'b11.
//   Package also holds functions sat_inc/sat_dec and localparams for the tag width (30-IDX_W).
//  Sub-module btb_table: storage arrays with a 1 read port (comb) and 1 write port (sync), valid-clear on rst.
//  Top level holds the hit/predict logic, update decode and perf counters.
// TESTING
//  1 Reset then PC_IF=0x100 -> pred_taken=0, pred_target=0x104; br_count=mispred_count=0.
//  2 Train upd pc=0x100 tgt=0x40 taken=1, then PC_IF=0x100.
//    -> next cycle pred_taken=1, pred_target=0x40; cnt=2.
//    -> two not-taken updates: cnt 1 then 0, pred_taken=0.
//  3 Saturation: 5 taken updates on 0x100 -> cnt stays 3; then one not-taken -> still predicts taken (cnt=2).
//  4 Alias: allocate 0x100, then taken update pc=0x200 (same idx when IDX_W=6) tgt=0x80.
//    -> PC_IF=0x100 misses; PC_IF=0x200 hits with target 0x80, cnt=2.
//  5 Same-cycle update+lookup of 0x300 (empty entry) -> that cycle pred_taken=0; next cycle pred_taken=1.
//    Not-taken miss on 0x500 -> no allocation.
//  6 Counters: 10 upd_valid with 3 upd_mispred, plus 2 upd_mispred without upd_valid -> br_count=10, mispred_count=3.
//    Assert rst together with an update -> both counters=0, entry not written.

Source files
------------

// File: rtl/branch_target_buffer_pkg.sv
// Shared types, constants and helpers for the branch target buffer.
// Holds the 2-bit predictor encodings, default geometry and saturating counter math.
// Nothing here carries state; it is imported by the table and the top level.
package branch_target_buffer_pkg;

    // Default geometry: 64 entries, tag is whatever is left of a word-aligned PC.
    localparam int IDX_W_DEF = 6;
    localparam int TAG_W_DEF = 30 - IDX_W_DEF;

    // Two-bit predictor states; bit 1 set means "predict taken".
    localparam logic [1:0] CNT_SNT = 2'b00;
    localparam logic [1:0] CNT_WNT = 2'b01;
    localparam logic [1:0] CNT_WT  = 2'b10;
    localparam logic [1:0] CNT_ST  = 2'b11;

    // Increment toward strongly-taken, holding at the top.
    function automatic logic [1:0] sat_inc(input logic [1:0] c);
        return (c == CNT_ST) ? CNT_ST : c + 2'd1;
    endfunction

    // Decrement toward strongly-not-taken, holding at the bottom.
    function automatic logic [1:0] sat_dec(input logic [1:0] c);
        return (c == CNT_SNT) ? CNT_SNT : c - 2'd1;
    endfunction

endpackage

// File: rtl/branch_target_buffer_btb_table.sv
// BTB storage: valid/tag/target/counter arrays, one comb lookup port, one sync RMW write port.
// Lookup is 0-cycle; writes land on the next rising edge (no write-to-read bypass).
// No backpressure; a write is accepted every cycle wr_en_i is high and rst is low.
module btb_table
    import branch_target_buffer_pkg::*;
#(
    parameter int IDX_W = IDX_W_DEF,
    parameter int TAG_W = 30 - IDX_W
) (
    input  logic              clk,
    input  logic              rst,
    // lookup port (IF side)
    input  logic [IDX_W-1:0]  rd_idx_i,
    output logic              rd_valid_o,
    output logic [TAG_W-1:0]  rd_tag_o,
    output logic [31:0]       rd_tgt_o,
    output logic [1:0]        rd_cnt_o,
    // write port (EX side); cur_* expose the addressed entry for read-modify-write
    input  logic [IDX_W-1:0]  wr_idx_i,
    output logic              cur_valid_o,
    output logic [TAG_W-1:0]  cur_tag_o,
    output logic [31:0]       cur_tgt_o,
    output logic [1:0]        cur_cnt_o,
    input  logic              wr_en_i,
    input  logic [TAG_W-1:0]  wr_tag_i,
    input  logic [31:0]       wr_tgt_i,
    input  logic [1:0]        wr_cnt_i
);

    localparam int ENTRIES = 2 ** IDX_W;

    logic [ENTRIES-1:0] valid_q;
    logic [TAG_W-1:0]   tag_q [ENTRIES];
    logic [31:0]        tgt_q [ENTRIES];
    logic [1:0]         cnt_q [ENTRIES];

    assign rd_valid_o  = valid_q[rd_idx_i];
    assign rd_tag_o    = tag_q[rd_idx_i];
    assign rd_tgt_o    = tgt_q[rd_idx_i];
    assign rd_cnt_o    = cnt_q[rd_idx_i];

    assign cur_valid_o = valid_q[wr_idx_i];
    assign cur_tag_o   = tag_q[wr_idx_i];
    assign cur_tgt_o   = tgt_q[wr_idx_i];
    assign cur_cnt_o   = cnt_q[wr_idx_i];

    // Valid bits: cleared by reset (which also drops any same-cycle write), set on write.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else if (wr_en_i) begin
            valid_q[wr_idx_i] <= 1'b1;
        end
    end

    // Payload arrays: no reset needed, an entry is ignored until its valid bit is set.
    always_ff @(posedge clk) begin
        if (wr_en_i && !rst) begin
            tag_q[wr_idx_i] <= wr_tag_i;
            tgt_q[wr_idx_i] <= wr_tgt_i;
            cnt_q[wr_idx_i] <= wr_cnt_i;
        end
    end

endmodule

// File: rtl/branch_target_buffer.sv
// Direct-mapped BTB with 2-bit predictors plus branch / mispredict perf counters.
// Prediction is combinational from PC_IF; EX training is visible one cycle after upd_valid.
// No backpressure: every upd_valid cycle is consumed; reset wins over a concurrent update.
module branch_target_buffer
    import branch_target_buffer_pkg::*;
#(
    parameter int         IDX_W    = IDX_W_DEF,
    parameter logic [1:0] CNT_INIT = CNT_WT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] PC_IF,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic [31:0] upd_target,
    input  logic        upd_taken,
    input  logic        upd_mispred,
    output logic [31:0] br_count,
    output logic [31:0] mispred_count
);

    localparam int TAG_W = 30 - IDX_W;

    // Lookup side
    logic [IDX_W-1:0] lk_idx;
    logic [TAG_W-1:0] lk_tag;
    logic             rd_valid;
    logic [TAG_W-1:0] rd_tag;
    logic [31:0]      rd_tgt;
    logic [1:0]       rd_cnt;
    logic             lk_hit;

    // Update side
    logic [IDX_W-1:0] up_idx;
    logic [TAG_W-1:0] up_tag;
    logic             cur_valid;
    logic [TAG_W-1:0] cur_tag;
    logic [31:0]      cur_tgt;
    logic [1:0]       cur_cnt;
    logic             up_hit;
    logic             wr_en;
    logic [31:0]      wr_tgt;
    logic [1:0]       wr_cnt;

    // Perf counters
    logic [31:0] br_count_q,      br_count_d;
    logic [31:0] mispred_count_q, mispred_count_d;

    // Byte offset of the update PC plays no part in indexing or tagging.
    logic unused_upd_pc_lsb;
    assign unused_upd_pc_lsb = ^upd_pc[1:0];

    assign lk_idx = PC_IF[IDX_W+1:2];
    assign lk_tag = PC_IF[31:IDX_W+2];
    assign up_idx = upd_pc[IDX_W+1:2];
    assign up_tag = upd_pc[31:IDX_W+2];

    btb_table #(
        .IDX_W (IDX_W),
        .TAG_W (TAG_W)
    ) u_table (
        .clk         (clk),
        .rst         (rst),
        .rd_idx_i    (lk_idx),
        .rd_valid_o  (rd_valid),
        .rd_tag_o    (rd_tag),
        .rd_tgt_o    (rd_tgt),
        .rd_cnt_o    (rd_cnt),
        .wr_idx_i    (up_idx),
        .cur_valid_o (cur_valid),
        .cur_tag_o   (cur_tag),
        .cur_tgt_o   (cur_tgt),
        .cur_cnt_o   (cur_cnt),
        .wr_en_i     (wr_en),
        .wr_tag_i    (up_tag),
        .wr_tgt_i    (wr_tgt),
        .wr_cnt_i    (wr_cnt)
    );

    // Prediction: taken only on a tag hit whose counter is in a taken state.
    always_comb begin
        lk_hit      = rd_valid && (rd_tag == lk_tag);
        pred_taken  = lk_hit && rd_cnt[1];
        pred_target = pred_taken ? rd_tgt : (PC_IF + 32'd4);
    end

    // Training decode: train on hit, allocate on taken miss, ignore not-taken miss.
    always_comb begin
        up_hit = cur_valid && (cur_tag == up_tag);
        wr_en  = 1'b0;
        wr_tgt = cur_tgt;
        wr_cnt = cur_cnt;
        if (upd_valid) begin
            if (up_hit) begin
                wr_en = 1'b1;
                if (upd_taken) begin
                    wr_cnt = sat_inc(cur_cnt);
                    wr_tgt = upd_target;
                end else begin
                    wr_cnt = sat_dec(cur_cnt);
                end
            end else if (upd_taken) begin
                wr_en  = 1'b1;
                wr_cnt = CNT_INIT;
                wr_tgt = upd_target;
            end
        end
    end

    // Perf counter next state; both wrap naturally at 2**32.
    always_comb begin
        br_count_d      = br_count_q + {31'd0, upd_valid};
        mispred_count_d = mispred_count_q + {31'd0, upd_valid & upd_mispred};
    end

    // Perf counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            br_count_q      <= '0;
            mispred_count_q <= '0;
        end else begin
            br_count_q      <= br_count_d;
            mispred_count_q <= mispred_count_d;
        end
    end

    assign br_count      = br_count_q;
    assign mispred_count = mispred_count_q;

endmodule

// File: tb/tb_branch_target_buffer.sv
// Self-checking bench for branch_target_buffer: directed scenarios then random traffic
// compared against an array-based predictor model.
module tb_branch_target_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] PC_IF;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic [31:0] upd_target;
    logic        upd_taken;
    logic        upd_mispred;
    logic [31:0] br_count;
    logic [31:0] mispred_count;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: 64 direct-mapped entries, counters kept as plain integers 0..3.
    bit          m_valid [64];
    int unsigned m_tag   [64];
    logic [31:0] m_tgt   [64];
    int          m_cnt   [64];
    logic [31:0] m_br;
    logic [31:0] m_mis;

    branch_target_buffer dut (
        .clk           (clk),
        .rst           (rst),
        .PC_IF         (PC_IF),
        .pred_taken    (pred_taken),
        .pred_target   (pred_target),
        .upd_valid     (upd_valid),
        .upd_pc        (upd_pc),
        .upd_target    (upd_target),
        .upd_taken     (upd_taken),
        .upd_mispred   (upd_mispred),
        .br_count      (br_count),
        .mispred_count (mispred_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", nm, obs, exp);
        end
    endtask

    function automatic int m_idx(input logic [31:0] pc);
        return int'((pc / 4) % 64);
    endfunction

    function automatic int unsigned m_tg(input logic [31:0] pc);
        return pc / 256;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
        m_br  = 32'd0;
        m_mis = 32'd0;
    endtask

    task automatic m_update(input logic [31:0] pc, input logic [31:0] tgt,
                            input logic tk, input logic mis);
        int  i;
        bit  hit;
        i   = m_idx(pc);
        hit = m_valid[i] && (m_tag[i] == m_tg(pc));
        m_br = m_br + 32'd1;
        if (mis) m_mis = m_mis + 32'd1;
        if (hit && tk) begin
            m_cnt[i] = (m_cnt[i] + 1 > 3) ? 3 : m_cnt[i] + 1;
            m_tgt[i] = tgt;
        end else if (hit) begin
            m_cnt[i] = (m_cnt[i] - 1 < 0) ? 0 : m_cnt[i] - 1;
        end else if (tk) begin
            m_valid[i] = 1'b1;
            m_tag[i]   = m_tg(pc);
            m_tgt[i]   = tgt;
            m_cnt[i]   = 2;
        end
    endtask

    task automatic m_lookup(input logic [31:0] pc, output logic tk, output logic [31:0] tgt);
        int i;
        i  = m_idx(pc);
        tk = m_valid[i] && (m_tag[i] == m_tg(pc)) && (m_cnt[i] >= 2);
        tgt = tk ? m_tgt[i] : pc + 32'd4;
    endtask

    // One update cycle; returns one time unit after the capturing edge.
    task automatic upd(input logic [31:0] pc, input logic [31:0] tgt,
                       input logic tk, input logic mis);
        upd_valid = 1'b1; upd_pc = pc; upd_target = tgt; upd_taken = tk; upd_mispred = mis;
        @(posedge clk);
        m_update(pc, tgt, tk, mis);
        #1;
        upd_valid = 1'b0; upd_mispred = 1'b0;
    endtask

    // Directed lookup with constant expectations; also cross-checks the model.
    task automatic look(input string nm, input logic [31:0] pc,
                        input logic etk, input logic [31:0] etgt);
        logic        mtk;
        logic [31:0] mtgt;
        PC_IF = pc;
        #1;
        m_lookup(pc, mtk, mtgt);
        chk({nm, "_taken"}, {31'd0, pred_taken}, {31'd0, etk});
        chk({nm, "_target"}, pred_target, etgt);
        chk({nm, "_model"}, {31'd0, mtk}, {31'd0, etk});
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); @(posedge clk);
        m_reset();
        #1;
        rst = 1'b0;
    endtask

    function automatic logic [31:0] rand_pc();
        return (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 7)) << 2)
               | 32'($urandom_range(0, 3));
    endfunction

    initial begin
        logic        etk;
        logic [31:0] etgt;

        rst = 1'b1; PC_IF = 32'h0; upd_valid = 1'b0; upd_pc = 32'h0;
        upd_target = 32'h0; upd_taken = 1'b0; upd_mispred = 1'b0;
        do_reset();

        // 1: reset state
        look("rst_lookup", 32'h100, 1'b0, 32'h104);
        chk("rst_br_count", br_count, 32'd0);
        chk("rst_mispred_count", mispred_count, 32'd0);

        // 2: allocate, then decay with not-taken updates
        upd(32'h100, 32'h40, 1'b1, 1'b0);
        look("alloc_hit", 32'h100, 1'b1, 32'h40);
        upd(32'h100, 32'h40, 1'b0, 1'b1);
        look("decay1", 32'h100, 1'b0, 32'h104);
        upd(32'h100, 32'h40, 1'b0, 1'b0);
        look("decay0", 32'h100, 1'b0, 32'h104);

        // 3: saturation at strongly taken
        for (int i = 0; i < 5; i++) upd(32'h100, 32'h40, 1'b1, 1'b0);
        upd(32'h100, 32'h40, 1'b0, 1'b1);
        look("sat_one_nt", 32'h100, 1'b1, 32'h40);
        upd(32'h100, 32'h40, 1'b0, 1'b0);
        look("sat_two_nt", 32'h100, 1'b0, 32'h104);

        // 4: alias replacement at the same index
        upd(32'h100, 32'h40, 1'b1, 1'b0);
        upd(32'h200, 32'h80, 1'b1, 1'b1);
        look("alias_old_miss", 32'h100, 1'b0, 32'h104);
        look("alias_new_hit", 32'h200, 1'b1, 32'h80);
        upd(32'h200, 32'h80, 1'b0, 1'b0);
        look("alias_init_weak", 32'h200, 1'b0, 32'h204);

        // 5: same-cycle lookup and update see pre-update contents
        PC_IF = 32'h300;
        upd_valid = 1'b1; upd_pc = 32'h300; upd_target = 32'h1234; upd_taken = 1'b1;
        #1;
        chk("same_cycle_taken", {31'd0, pred_taken}, 32'd0);
        chk("same_cycle_target", pred_target, 32'h304);
        @(posedge clk);
        m_update(32'h300, 32'h1234, 1'b1, 1'b0);
        #1;
        upd_valid = 1'b0;
        look("next_cycle", 32'h300, 1'b1, 32'h1234);
        upd(32'h500, 32'h9990, 1'b0, 1'b0);
        look("nt_miss_no_alloc", 32'h500, 1'b0, 32'h504);
        look("nt_miss_kept", 32'h300, 1'b1, 32'h1234);

        // 6: perf counters, mispred without valid ignored
        do_reset();
        for (int i = 0; i < 10; i++)
            upd(32'h1000 + 32'(i * 4), 32'h0, 1'b0, (i % 3 == 0) && (i < 9));
        for (int i = 0; i < 2; i++) begin
            upd_mispred = 1'b1;
            @(posedge clk);
            #1;
            upd_mispred = 1'b0;
        end
        chk("cnt_br", br_count, 32'd10);
        chk("cnt_mispred", mispred_count, 32'd3);
        chk("cnt_br_model", m_br, 32'd10);

        // reset beats a concurrent update
        rst = 1'b1;
        upd_valid = 1'b1; upd_pc = 32'h700; upd_target = 32'h77; upd_taken = 1'b1; upd_mispred = 1'b1;
        @(posedge clk);
        m_reset();
        #1;
        rst = 1'b0; upd_valid = 1'b0; upd_mispred = 1'b0;
        chk("rstupd_br", br_count, 32'd0);
        chk("rstupd_mispred", mispred_count, 32'd0);
        look("rstupd_no_write", 32'h700, 1'b0, 32'h704);

        // Random traffic against the model
        for (int it = 0; it < 600; it++) begin
            PC_IF       = rand_pc();
            upd_valid   = ($urandom_range(0, 2) != 0);
            upd_pc      = rand_pc();
            upd_target  = $urandom;
            upd_taken   = 1'($urandom_range(0, 1));
            upd_mispred = 1'($urandom_range(0, 1));
            rst         = ($urandom_range(0, 79) == 0);
            #1;
            m_lookup(PC_IF, etk, etgt);
            chk("rand_taken", {31'd0, pred_taken}, {31'd0, etk});
            chk("rand_target", pred_target, etgt);
            @(posedge clk);
            if (rst) m_reset();
            else if (upd_valid) m_update(upd_pc, upd_target, upd_taken, upd_mispred);
            #1;
            chk("rand_br", br_count, m_br);
            chk("rand_mispred", mispred_count, m_mis);
        end
        rst = 1'b0; upd_valid = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
